ldconv_unit: RTL and testbench

//   Load path of the core, mirroring the store converter: issues word-aligned

---
 rtl/ldconv_unit.sv | 152 +++++++++++++++
 tb/tb_ldconv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ldconv_unit.sv
// ldconv_unit: load converter between EX and the data memory port.
// Issues word-aligned reads for LB/LH/LW/LBU/LHU, then selects and
// sign/zero-extends the addressed byte, half or word from the returned data.
// Optional feature macro: LDCONV_LOAD_SPLIT_EN. When it is defined, a
// misaligned load is served by two aligned reads that are merged. When it is
// undefined, a misaligned load completes at once with err=1.
module ldconv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] out
);

    typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_t;

    state_t     state;
    logic [2:0] f3;     // latched funct3
    logic [1:0] off;    // latched byte offset within the word
`ifdef LDCONV_LOAD_SPLIT_EN
    logic [31:0] w0;    // first word of a split access
`endif

    // Only funct3 is consumed from the instruction.
    logic unused_ir;
    assign unused_ir = ^{ir[31:15], ir[11:0]};

    // Funct3 codes 011, 110 and 111 are not loads.
    function automatic logic illegal_f3(input logic [2:0] f);
        illegal_f3 = (f == 3'b011) || (f[2:1] == 2'b11);
    endfunction

    // An access is misaligned when it runs past the end of the word.
    // Halves are misaligned only at offset 3; byte loads never are.
    function automatic logic misaligned(input logic [2:0] f, input logic [1:0] o);
        misaligned = ((f[1:0] == 2'b01) && (o == 2'd3)) ||
                     ((f == 3'b010) && (o != 2'd0));
    endfunction

    // Shift the {w1,w0} pair down to the addressed byte, then extend.
    function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] o,
                                            input logic [63:0] dw);
        logic [31:0] d;
        d = 32'(dw >> {o, 3'b000});
        case (f)
            3'b000:  extract = {{24{d[7]}}, d[7:0]};
            3'b100:  extract = {24'b0, d[7:0]};
            3'b001:  extract = {{16{d[15]}}, d[15:0]};
            3'b101:  extract = {16'b0, d[15:0]};
            default: extract = d;
        endcase
    endfunction

    logic [2:0] s_f3;
    logic [1:0] s_off;
    logic       s_reject;

    // Decode of the request presented with start.
    always_comb begin
        s_f3  = ir[14:12];
        s_off = addr[1:0];
`ifdef LDCONV_LOAD_SPLIT_EN
        s_reject = illegal_f3(s_f3);
`else
        s_reject = illegal_f3(s_f3) || misaligned(s_f3, s_off);
`endif
    end

    // Control FSM with registered outputs; done is a one-cycle pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            f3       <= 3'b000;
            off      <= 2'b00;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            out      <= 32'h0;
`ifdef LDCONV_LOAD_SPLIT_EN
            w0       <= 32'h0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        f3  <= s_f3;
                        off <= s_off;
                        if (s_reject) begin
                            // Rejected loads never touch memory.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            out   <= 32'h0;
                        end else begin
                            state    <= REQ0;
                            mem_req  <= 1'b1;
                            busy     <= 1'b1;
                            mem_addr <= {addr[31:2], 2'b00};
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ0: begin
                    if (mem_ack) begin
`ifdef LDCONV_LOAD_SPLIT_EN
                        if (misaligned(f3, off)) begin
                            // Request stays up; the address moves to the next word.
                            w0       <= mem_rdata;
                            state    <= REQ1;
                            mem_addr <= mem_addr + 32'd4;
                        end else
`endif
                        begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b0;
                            out     <= extract(f3, off, {32'h0, mem_rdata});
                        end
                    end
                end
`ifdef LDCONV_LOAD_SPLIT_EN
                REQ1: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        out     <= extract(f3, off, {mem_rdata, w0});
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldconv_unit.sv
// Testbench for ldconv_unit: directed scenarios followed by random loads.
// Each result is checked against a byte-level reference model of the load.
module tb_ldconv_unit;

`ifdef LDCONV_LOAD_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [31:0] addr = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_out = 32'h0;

    ldconv_unit dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .addr(addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err), .out(out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: gather the addressed bytes from the little-endian pair of
    // words, extend, and count the reads the load needs.
    function automatic void ref_load(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] w0, input logic [31:0] w1,
                                     output bit e, output logic [31:0] o, output int nr);
        logic [7:0] b [8];
        int n;
        int ofs;
        bit sgn;
        ofs = int'(a[1:0]);
        for (int i = 0; i < 4; i++) begin
            b[i]   = w0[8*i +: 8];
            b[i+4] = w1[8*i +: 8];
        end
        case (f)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        sgn = (f[2] == 1'b0);
        e = 1'b0; o = 32'h0; nr = 1;
        if (n == 0) begin e = 1'b1; nr = 0; return; end
        if (ofs + n > 4) begin
            if (!SPLIT) begin e = 1'b1; nr = 0; return; end
            nr = 2;
        end
        for (int i = 0; i < n; i++) o[8*i +: 8] = b[ofs+i];
        if (sgn && n < 4 && b[ofs+n-1][7])
            for (int i = n; i < 4; i++) o[8*i +: 8] = 8'hFF;
    endfunction

    // Issue one load and act as the memory; lat0/lat1 are the wait cycles
    // before each ack. With now=1 start is raised in the current cycle.
    task automatic run_load(input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input int lat0, input int lat1, input bit now);
        bit e;
        logic [31:0] o;
        logic [31:0] base;
        int nr;
        int lat;
        ref_load(f, a, w0, w1, e, o, nr);
        if (!now) @(negedge clock);
        ir = $urandom; ir[14:12] = f; addr = a; start = 1'b1;
        @(negedge clock);
        start = 1'b0; addr = $urandom;
        base = {a[31:2], 2'b00};
        for (int r = 0; r < nr; r++) begin
            lat = (r == 0) ? lat0 : lat1;
            for (int k = 0; k <= lat; k++) begin
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_addr", mem_addr, base + 32'(4 * r));
                chk("busy", 32'(busy), 32'd1);
                chk("done_low", 32'(done), 32'd0);
                chk("out_hold", out, last_out);
                if (k == lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = (r == 0) ? w0 : w1;
                end
                @(negedge clock);
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
        end
        chk("done", 32'(done), 32'd1);
        chk("err", 32'(err), 32'(e));
        chk("out", out, o);
        chk("busy_end", 32'(busy), 32'd0);
        chk("mem_req_end", 32'(mem_req), 32'd0);
        last_out = o;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out", out, 32'h0);
        reset = 1'b1;

        // 1: LB, zero-wait memory
        run_load(3'b000, 32'h103, 32'h80FF_1234, 32'h0, 0, 0, 1'b0);
        chk("t1_out", out, 32'hFFFF_FF80);

        // 2: LHU with delayed ack
        run_load(3'b101, 32'h202, 32'hBEEF_0000, 32'h0, 3, 0, 1'b0);
        chk("t2_out", out, 32'h0000_BEEF);

        // 3: misaligned LW
        run_load(3'b010, 32'h301, 32'h4433_2211, 32'h8877_6655, 1, 2, 1'b0);
        chk("t3_out", out, SPLIT ? 32'h5544_3322 : 32'h0);
        chk("t3_err", 32'(err), SPLIT ? 32'd0 : 32'd1);

        // 4: illegal funct3
        run_load(3'b110, 32'h40, 32'h1, 32'h2, 0, 0, 1'b0);
        chk("t4_err", 32'(err), 32'd1);

        // 5: reset while a request awaits its ack
        run_load(3'b001, 32'h10, 32'h0000_8001, 32'h0, 0, 0, 1'b0);
        @(negedge clock);
        ir = 32'h0000_2000; addr = 32'h0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t5_req_up", 32'(mem_req), 32'd1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_out", out, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("t5_late_done", 32'(done), 32'd0);
        chk("t5_late_req", 32'(mem_req), 32'd0);
        chk("t5_late_out", out, 32'h0);
        last_out = 32'h0;
        run_load(3'b010, 32'h0, 32'hCAFE_F00D, 32'h0, 1, 0, 1'b0);
        chk("t5_lw", out, 32'hCAFE_F00D);

        // 6: back-to-back, second start on the done cycle
        run_load(3'b000, 32'h502, 32'h0012_3456, 32'h0, 0, 0, 1'b0);
        run_load(3'b100, 32'h601, 32'h0000_9A00, 32'h0, 2, 0, 1'b1);
        chk("t6_out", out, 32'h0000_009A);

        // Random loads, including address wrap and back-to-back starts
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            ra = (i % 10 == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            run_load(3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
